// File: rtl/calculadora_seq.sv
`default_nettype none
// ============================================================================
// calculadora_seq : sequential ALU, single-cycle 000-100, shift-add multiply,
//                   restoring divide/remainder, start/busy handshake
// Revision 1.0
// ============================================================================
module calculadora_seq #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] entrada_A,
    input  logic [LARGURA-1:0] entrada_B,
    input  logic [2:0]         codigo,
    input  logic               inicio,
    output logic               ocupado,
    output logic [LARGURA-1:0] saida,
    output logic               valido_saida,
    output logic               carry,
    output logic               zero,
    output logic               erro
);

    localparam int CW = $clog2(LARGURA);
    localparam logic [CW-1:0] CONT_INI = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t              estado, prox_estado;
    logic [CW-1:0]        contador;
    logic [2:0]           op_reg;
    logic [LARGURA-1:0]   a_reg, b_reg;
    logic [2*LARGURA-1:0] produto, produto_prox;
    logic [LARGURA:0]     resto, resto_prox;
    logic [LARGURA-1:0]   quociente, quociente_prox;
    logic [LARGURA:0]     soma;
    logic [LARGURA+1:0]   deslocado;
    logic                 cabe;
    logic                 aceita, multiciclo;
    logic [LARGURA-1:0]   res_simples, res_multi;
    logic                 carry_simples, erro_simples, carry_multi;

    assign aceita     = inicio && (estado == OCIOSO);
    assign multiciclo = aceita && codigo[2] && (|codigo[1:0]) && (entrada_B != '0);
    assign ocupado    = (estado != OCIOSO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (multiciclo) prox_estado = CALCULA;
            CALCULA: if (contador == '0) prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // 110/111 only reach this path when B==0, so they always carry the error result
    always_comb begin
        res_simples   = '0;
        carry_simples = 1'b0;
        erro_simples  = 1'b0;
        case (codigo)
            3'b001: res_simples = entrada_A;
            3'b010: res_simples = entrada_B;
            3'b011: {carry_simples, res_simples} = {1'b0, entrada_A} + {1'b0, entrada_B};
            3'b100: begin
                res_simples   = entrada_A - entrada_B;
                carry_simples = (entrada_A < entrada_B);
            end
            3'b110: begin
                res_simples  = '1;
                erro_simples = 1'b1;
            end
            3'b111: begin
                res_simples  = entrada_A;
                erro_simples = 1'b1;
            end
            default: res_simples = '0;
        endcase
    end

    // Multiplier and divider step every CALCULA cycle; op_reg picks the result at FIM
    always_comb begin
        soma           = {1'b0, produto[2*LARGURA-1:LARGURA]} + (produto[0] ? {1'b0, a_reg} : '0);
        produto_prox   = {soma, produto[LARGURA-1:1]};
        deslocado      = {resto, quociente[LARGURA-1]};
        cabe           = (deslocado >= {2'b00, b_reg});
        resto_prox     = cabe ? (LARGURA+1)'(deslocado - {2'b00, b_reg}) : (LARGURA+1)'(deslocado);
        quociente_prox = {quociente[LARGURA-2:0], cabe};
    end

    always_comb begin
        res_multi   = '0;
        carry_multi = 1'b0;
        case (op_reg)
            3'b101: begin
                res_multi   = produto[LARGURA-1:0];
                carry_multi = |produto[2*LARGURA-1:LARGURA];
            end
            3'b110:  res_multi = quociente;
            default: res_multi = resto[LARGURA-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador     <= '0;
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            produto      <= '0;
            resto        <= '0;
            quociente    <= '0;
            saida        <= '0;
            valido_saida <= 1'b0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            erro         <= 1'b0;
        end else begin
            valido_saida <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        op_reg    <= codigo;
                        a_reg     <= entrada_A;
                        b_reg     <= entrada_B;
                        contador  <= CONT_INI;
                        produto   <= {{LARGURA{1'b0}}, entrada_B};
                        resto     <= '0;
                        quociente <= entrada_A;
                        if (!multiciclo) begin
                            saida        <= res_simples;
                            carry        <= carry_simples;
                            erro         <= erro_simples;
                            zero         <= (res_simples == '0);
                            valido_saida <= 1'b1;
                        end
                    end
                end
                CALCULA: begin
                    produto   <= produto_prox;
                    resto     <= resto_prox;
                    quociente <= quociente_prox;
                    contador  <= contador - CW'(1);
                end
                FIM: begin
                    saida        <= res_multi;
                    carry        <= carry_multi;
                    erro         <= 1'b0;
                    zero         <= (res_multi == '0);
                    valido_saida <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calculadora_seq.sv
`default_nettype none
// ============================================================================
// tb_calculadora_seq : scoreboard bench, random + directed stimulus for calculadora_seq
// Revision 1.0
// ============================================================================
module tb_calculadora_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] entrada_A, entrada_B;
    logic [2:0]   codigo;
    logic         inicio;
    logic         ocupado;
    logic [W-1:0] saida;
    logic         valido_saida, carry, zero, erro;

    calculadora_seq #(.LARGURA(W)) dut (
        .clk(clk), .rst_n(rst_n), .entrada_A(entrada_A), .entrada_B(entrada_B),
        .codigo(codigo), .inicio(inicio), .ocupado(ocupado), .saida(saida),
        .valido_saida(valido_saida), .carry(carry), .zero(zero), .erro(erro)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c, z, e;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0, busy_left = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t modelo(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        exp_t   x;
        longint ua = a, ub = b, m = longint'(1) << W, r = 0;
        x.c = 1'b0; x.e = 1'b0; x.due = 0;
        case (op)
            3'd0: r = 0;
            3'd1: r = ua;
            3'd2: r = ub;
            3'd3: begin r = (ua + ub) % m; x.c = (ua + ub) >= m; end
            3'd4: begin r = (ua - ub + m) % m; x.c = ua < ub; end
            3'd5: begin r = (ua * ub) % m; x.c = (ua * ub) >= m; end
            3'd6: if (ub == 0) begin r = m - 1; x.e = 1'b1; end else r = ua / ub;
            default: if (ub == 0) begin r = ua; x.e = 1'b1; end else r = ua % ub;
        endcase
        x.s = r[W-1:0];
        x.z = (r == 0);
        return x;
    endfunction

    // Reference: decide accepts from the bench's own busy model and schedule results
    always @(posedge clk) begin
        exp_t x;
        logic mc;
        cyc = cyc + 1;
        if (!rst_n) begin
            busy_left = 0;
            sb.delete();
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
        end else if (inicio) begin
            x  = modelo(entrada_A, entrada_B, codigo);
            mc = (codigo >= 3'd5) && (entrada_B != 0);
            x.due = mc ? cyc + W + 1 : cyc;
            sb.push_back(x);
            if (mc) busy_left = W + 1;
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            total++;
            if (ocupado !== 1'b0 || valido_saida !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: ocupado=%b valido=%b required 0 0", ocupado, valido_saida);
            end
        end else begin
            total++;
            if (ocupado !== (busy_left != 0)) begin
                bad++;
                $display("FAIL ocupado cyc=%0d: got %b required %b", cyc, ocupado, busy_left != 0);
            end
            if (valido_saida === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valido cyc=%0d saida=%0d", cyc, saida);
                end else begin
                    x = sb.pop_front();
                    if (saida !== x.s || carry !== x.c || zero !== x.z || erro !== x.e || cyc != x.due) begin
                        bad++;
                        $display("FAIL result cyc=%0d: got s=%0d c=%b z=%b e=%b required s=%0d c=%b z=%b e=%b at cyc=%0d",
                                 cyc, saida, carry, zero, erro, x.s, x.c, x.z, x.e, x.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_result cyc=%0d required s=%0d due=%0d", cyc, sb[0].s, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic esperar_ocioso();
        for (int i = 0; i < 100 && busy_left != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Issue one op (DUT idle) and check its result against literal values
    task automatic dirigido(string nome, int a, int b, logic [2:0] op,
                            int es, logic ec, logic ez, logic ee, int elat);
        int n;
        @(posedge clk); #1;
        entrada_A = W'(a); entrada_B = W'(b); codigo = op; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        entrada_A = W'($urandom); entrada_B = W'($urandom); codigo = 3'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (valido_saida === 1'b1 || n > 30) break;
            n++;
        end
        total++;
        if (saida !== W'(es) || carry !== ec || zero !== ez || erro !== ee || n != elat) begin
            bad++;
            $display("FAIL %s: got s=%0d c=%b z=%b e=%b lat=%0d required s=%0d c=%b z=%b e=%b lat=%0d",
                     nome, saida, carry, zero, erro, n, es, ec, ez, ee, elat);
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; inicio = 1'b0; entrada_A = '0; entrada_B = '0; codigo = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        total++;
        if (saida !== '0 || ocupado !== 1'b0 || valido_saida !== 1'b0 || carry !== 1'b0 || erro !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: s=%0d ocupado=%b valido=%b c=%b e=%b required all 0",
                     saida, ocupado, valido_saida, carry, erro);
        end

        dirigido("add_wrap",    200, 100, 3'b011,  44, 1'b1, 1'b0, 1'b0, 0);
        dirigido("sub_borrow",    5,   7, 3'b100, 254, 1'b1, 1'b0, 1'b0, 0);
        dirigido("op_zero",      77,  33, 3'b000,   0, 1'b0, 1'b1, 1'b0, 0);
        dirigido("pass_a",       77,  33, 3'b001,  77, 1'b0, 1'b0, 1'b0, 0);
        dirigido("pass_b",       77,  33, 3'b010,  33, 1'b0, 1'b0, 1'b0, 0);
        dirigido("mul_ovf",      20,  13, 3'b101,   4, 1'b1, 1'b0, 1'b0, W + 1);
        dirigido("mul_255",      15,  17, 3'b101, 255, 1'b0, 1'b0, 1'b0, W + 1);
        dirigido("div",         200,   7, 3'b110,  28, 1'b0, 1'b0, 1'b0, W + 1);
        dirigido("rem",         200,   7, 3'b111,   4, 1'b0, 1'b0, 1'b0, W + 1);
        dirigido("div_by_zero",   9,   0, 3'b110, 255, 1'b0, 1'b0, 1'b1, 0);
        dirigido("rem_by_zero",   9,   0, 3'b111,   9, 1'b0, 1'b0, 1'b1, 0);
        dirigido("div_small",     3, 255, 3'b110,   0, 1'b0, 1'b1, 1'b0, W + 1);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        entrada_A = 8'd20; entrada_B = 8'd13; codigo = 3'b101; inicio = 1'b1;
        @(posedge clk); #1 inicio = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (saida !== '0 || ocupado !== 1'b0 || valido_saida !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_mul: s=%0d ocupado=%b valido=%b required 0 0 0", saida, ocupado, valido_saida);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        dirigido("mul_after_reset", 20, 13, 3'b101, 4, 1'b1, 1'b0, 1'b0, W + 1);

        // inicio held through a divide: one result per accept, re-accept right after ocupado falls
        pulses = 0;
        @(posedge clk); #1;
        entrada_A = 8'd200; entrada_B = 8'd7; codigo = 3'b110; inicio = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == W + 3) inicio = 1'b0;
            @(negedge clk);
            if (valido_saida === 1'b1) pulses++;
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL held_inicio_pulses: got %0d required 2", pulses);
        end

        // Random traffic, including requests while busy and zero divisors
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            inicio    = ($urandom_range(0, 2) == 0);
            entrada_A = W'($urandom);
            entrada_B = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            codigo    = 3'($urandom_range(0, 7));
        end
        inicio = 1'b0;
        esperar_ocioso();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results never seen", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
